// File: rtl/multi_wave_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_wave_pkg
// Brief    : Shared mode/field codes, FSM states and LFSR constants.
// Revision : 1.0
// ============================================================================
package multi_wave_pkg;

   typedef enum logic [1:0] {
      MODE_SAW    = 2'b00,
      MODE_TRI    = 2'b01,
      MODE_SQUARE = 2'b10,
      MODE_NOISE  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      FIELD_INC  = 2'b00,
      FIELD_AMP  = 2'b01,
      FIELD_MODE = 2'b10,
      FIELD_DUTY = 2'b11
   } field_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHAPE = 2'd1,
      S_SCALE = 2'd2,
      S_OUT   = 2'd3
   } state_e;

   localparam logic [15:0] c_lfsr_seed = 16'hACE1;
   // Feedback taps 16, 14, 13, 11 as bit positions 15, 13, 12, 10
   localparam logic [15:0] c_lfsr_taps = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {state[14:0], ^(state & c_lfsr_taps)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_wave_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_wave_generator_if
// Brief    : Configuration, request and sample-output bundle of the generator.
// Revision : 1.0
// ============================================================================
interface multi_wave_generator_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 4
);
   localparam int CHAN_W = $clog2(CHANNELS);

   logic [DATA_WIDTH-1:0] cfg_data_i;
   logic [CHAN_W-1:0]     cfg_chan_i;
   logic [1:0]            cfg_field_i;
   logic                  cfg_valid_strobe_i;
   logic                  sync_strobe_i;
   logic                  next_data_strobe_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic [CHAN_W-1:0]     data_chan_o;
   logic                  data_out_valid_strobe_o;
   logic                  busy_o;
   logic                  round_done_strobe_o;

   modport master (
      output cfg_data_i, cfg_chan_i, cfg_field_i, cfg_valid_strobe_i,
      output sync_strobe_i, next_data_strobe_i,
      input  data_o, data_chan_o, data_out_valid_strobe_o, busy_o, round_done_strobe_o
   );

   modport slave (
      input  cfg_data_i, cfg_chan_i, cfg_field_i, cfg_valid_strobe_i,
      input  sync_strobe_i, next_data_strobe_i,
      output data_o, data_chan_o, data_out_valid_strobe_o, busy_o, round_done_strobe_o
   );
endinterface
`default_nettype wire

// File: rtl/multi_wave_generator_wave_shaper.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper
// Brief    : Combinational phase-to-sample mapping for the four wave modes.
// Revision : 1.0
// ============================================================================
module wave_shaper
   import multi_wave_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_u,
   input  mode_e                 i_mode,
   input  logic [DATA_WIDTH-1:0] i_duty,
   input  logic [15:0]           i_lfsr,
   output logic [DATA_WIDTH-1:0] o_shaped
);
   localparam logic [DATA_WIDTH-1:0] c_pos_full = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] c_neg_full = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] w_tri_shift;
   logic [DATA_WIDTH-1:0] w_tri_fold;
   logic [DATA_WIDTH-1:0] w_noise;

   assign w_tri_shift = {i_u[DATA_WIDTH-2:0], 1'b0};
   assign w_tri_fold  = i_u[DATA_WIDTH-1] ? ~w_tri_shift : w_tri_shift;

   // Noise takes the LFSR left-aligned so any sample width works
   if (DATA_WIDTH < 16) begin : g_noise_narrow
      logic w_unused_lfsr;
      assign w_noise       = i_lfsr[15 -: DATA_WIDTH];
      assign w_unused_lfsr = ^i_lfsr[15-DATA_WIDTH:0];
   end else if (DATA_WIDTH == 16) begin : g_noise_exact
      assign w_noise = i_lfsr;
   end else begin : g_noise_wide
      assign w_noise = {i_lfsr, {(DATA_WIDTH-16){1'b0}}};
   end

   always_comb begin
      o_shaped = '0;
      case (i_mode)
         MODE_SAW:    o_shaped = {~i_u[DATA_WIDTH-1], i_u[DATA_WIDTH-2:0]};
         MODE_TRI:    o_shaped = {~w_tri_fold[DATA_WIDTH-1], w_tri_fold[DATA_WIDTH-2:0]};
         MODE_SQUARE: o_shaped = (i_u < i_duty) ? c_pos_full : c_neg_full;
         MODE_NOISE:  o_shaped = w_noise;
         default:     o_shaped = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multi_wave_generator.sv
`default_nettype none
// ============================================================================
// Module   : multi_wave_generator
// Brief    : Multi-channel DDS wave generator, one sample per channel per round.
// Revision : 1.0
// ============================================================================
module multi_wave_generator
   import multi_wave_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int PHASE_WIDTH = 8,
   parameter int CHANNELS    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   multi_wave_generator_if.slave   bus
);
   localparam int                    CHAN_W       = $clog2(CHANNELS);
   localparam logic [CHAN_W-1:0]     c_last_chan  = CHAN_W'(CHANNELS - 1);
   localparam logic [DATA_WIDTH-1:0] c_duty_reset = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_e r_state;
   state_e w_state_next;
   logic   w_start;
   logic   w_shape;
   logic   w_scale;
   logic   w_out;
   logic   w_last;

   logic [DATA_WIDTH-1:0]  r_inc   [CHANNELS];
   logic [DATA_WIDTH-1:0]  r_amp   [CHANNELS];
   mode_e                  r_mode  [CHANNELS];
   logic [DATA_WIDTH-1:0]  r_duty  [CHANNELS];
   logic [PHASE_WIDTH-1:0] r_phase [CHANNELS];

   logic [CHAN_W-1:0]       r_chan;
   logic [15:0]             r_lfsr;
   logic [DATA_WIDTH-1:0]   r_shaped;
   logic [DATA_WIDTH-1:0]   r_scaled;
   logic [DATA_WIDTH-1:0]   w_shaped;
   logic [DATA_WIDTH-1:0]   w_u;
   logic signed [2*DATA_WIDTH:0] w_prod;

   logic [DATA_WIDTH-1:0] r_data;
   logic [CHAN_W-1:0]     r_data_chan;
   logic                  r_valid;
   logic                  r_round_done;

   always_ff @(posedge clk_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_shape      = 1'b0;
      w_scale      = 1'b0;
      w_out        = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.next_data_strobe_i) begin
               w_start      = 1'b1;
               w_state_next = S_SHAPE;
            end
         end
         S_SHAPE: begin
            w_shape      = 1'b1;
            w_state_next = S_SCALE;
         end
         S_SCALE: begin
            w_scale      = 1'b1;
            w_state_next = S_OUT;
         end
         S_OUT: begin
            w_out        = 1'b1;
            w_last       = (r_chan == c_last_chan);
            w_state_next = w_last ? S_IDLE : S_SHAPE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_inc[i]  <= '0;
            r_amp[i]  <= '0;
            r_mode[i] <= MODE_SAW;
            r_duty[i] <= c_duty_reset;
         end
      end else if (bus.cfg_valid_strobe_i && (int'(bus.cfg_chan_i) < CHANNELS)) begin
         case (field_e'(bus.cfg_field_i))
            FIELD_INC:  r_inc[bus.cfg_chan_i]  <= bus.cfg_data_i;
            FIELD_AMP:  r_amp[bus.cfg_chan_i]  <= bus.cfg_data_i;
            FIELD_MODE: r_mode[bus.cfg_chan_i] <= mode_e'(bus.cfg_data_i[1:0]);
            FIELD_DUTY: r_duty[bus.cfg_chan_i] <= bus.cfg_data_i;
            default: ;
         endcase
      end
   end

   // A sync in the same cycle as a SHAPE step overrides the phase advance
   always_ff @(posedge clk_i) begin
      if (!rst_i || bus.sync_strobe_i) begin
         for (int i = 0; i < CHANNELS; i++) r_phase[i] <= '0;
      end else if (w_shape) begin
         r_phase[r_chan] <= r_phase[r_chan] + PHASE_WIDTH'(r_inc[r_chan]);
      end
   end

   assign w_u = r_phase[r_chan][PHASE_WIDTH-1 -: DATA_WIDTH];

   wave_shaper #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shaper (
      .i_u      (w_u),
      .i_mode   (r_mode[r_chan]),
      .i_duty   (r_duty[r_chan]),
      .i_lfsr   (r_lfsr),
      .o_shaped (w_shaped)
   );

   assign w_prod = $signed({{(DATA_WIDTH+1){r_shaped[DATA_WIDTH-1]}}, r_shaped})
                 * $signed({{(DATA_WIDTH+1){1'b0}}, r_amp[r_chan]});

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_chan       <= '0;
         r_lfsr       <= c_lfsr_seed;
         r_shaped     <= '0;
         r_scaled     <= '0;
         r_data       <= '0;
         r_data_chan  <= '0;
         r_valid      <= 1'b0;
         r_round_done <= 1'b0;
      end else begin
         r_valid      <= 1'b0;
         r_round_done <= 1'b0;
         if (w_start) r_chan <= '0;
         if (w_shape) begin
            r_shaped <= w_shaped;
            r_lfsr   <= lfsr_next(r_lfsr);
         end
         if (w_scale) r_scaled <= DATA_WIDTH'(w_prod >>> DATA_WIDTH);
         if (w_out) begin
            r_data       <= r_scaled;
            r_data_chan  <= r_chan;
            r_valid      <= 1'b1;
            r_round_done <= w_last;
            if (!w_last) r_chan <= r_chan + CHAN_W'(1);
         end
      end
   end

   assign bus.data_o                  = r_data;
   assign bus.data_chan_o             = r_data_chan;
   assign bus.data_out_valid_strobe_o = r_valid;
   assign bus.round_done_strobe_o     = r_round_done;
   assign bus.busy_o                  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multi_wave_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_wave_generator
// Brief    : Directed self-checking bench for multi_wave_generator (W=8, CH=4).
// Revision : 1.0
// ============================================================================
module tb_multi_wave_generator;
   import multi_wave_pkg::*;

   localparam int DW = 8;
   localparam int PW = 8;
   localparam int CH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_wave_generator_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

   multi_wave_generator #(
      .DATA_WIDTH  (DW),
      .PHASE_WIDTH (PW),
      .CHANNELS    (CH)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] got_data  [CH];
   int            got_cycle [CH];
   logic [1:0]    got_chan  [CH];
   logic          got_done  [CH];
   logic [DW-1:0] chan_data [CH];
   int            strobe_cnt;
   logic          busy_mid;
   logic          busy_end;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n                  = 1'b0;
      bus.cfg_data_i         = '0;
      bus.cfg_chan_i         = '0;
      bus.cfg_field_i        = '0;
      bus.cfg_valid_strobe_i = 1'b0;
      bus.sync_strobe_i      = 1'b0;
      bus.next_data_strobe_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] field, input logic [7:0] val);
      bus.cfg_chan_i         = 2'(ch);
      bus.cfg_field_i        = field;
      bus.cfg_data_i         = val;
      bus.cfg_valid_strobe_i = 1'b1;
      tick();
      bus.cfg_valid_strobe_i = 1'b0;
   endtask

   // Issue one request and record every strobe seen in the following 14 cycles
   task automatic do_round();
      strobe_cnt = 0;
      for (int i = 0; i < CH; i++) chan_data[i] = 'x;
      bus.next_data_strobe_i = 1'b1;
      tick();
      bus.next_data_strobe_i = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) busy_mid = bus.busy_o;
         if (bus.data_out_valid_strobe_o) begin
            if (strobe_cnt < CH) begin
               got_data[strobe_cnt]  = bus.data_o;
               got_cycle[strobe_cnt] = k;
               got_chan[strobe_cnt]  = bus.data_chan_o;
               got_done[strobe_cnt]  = bus.round_done_strobe_o;
            end
            chan_data[bus.data_chan_o] = bus.data_o;
            strobe_cnt++;
         end
      end
      busy_end = bus.busy_o;
   endtask

   task automatic test_reset();
      apply_reset();
      tests_run++;
      if (bus.data_o !== 8'h00) begin
         tests_failed++; $display("FAIL reset_data: got %0h expected 0", bus.data_o);
      end
      tests_run++;
      if (bus.data_chan_o !== 2'd0) begin
         tests_failed++; $display("FAIL reset_chan: got %0d expected 0", bus.data_chan_o);
      end
      tests_run++;
      if (bus.data_out_valid_strobe_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.data_out_valid_strobe_o);
      end
      tests_run++;
      if (bus.busy_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
      end
      tests_run++;
      if (bus.round_done_strobe_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.round_done_strobe_o);
      end
   endtask

   task automatic test_defaults();
      apply_reset();
      do_round();
      tests_run++;
      if (strobe_cnt !== 4) begin
         tests_failed++; $display("FAIL default_strobes: got %0d expected 4", strobe_cnt);
      end
      tests_run++;
      if (busy_mid !== 1'b1) begin
         tests_failed++; $display("FAIL default_busy_mid: got %b expected 1", busy_mid);
      end
      tests_run++;
      if (busy_end !== 1'b0) begin
         tests_failed++; $display("FAIL default_busy_end: got %b expected 0", busy_end);
      end
      for (int i = 0; i < CH && i < strobe_cnt; i++) begin
         tests_run++;
         if (got_cycle[i] !== 3 * (i + 1)) begin
            tests_failed++; $display("FAIL default_cycle%0d: got %0d expected %0d", i, got_cycle[i], 3 * (i + 1));
         end
         tests_run++;
         if (got_chan[i] !== 2'(i)) begin
            tests_failed++; $display("FAIL default_chan%0d: got %0d expected %0d", i, got_chan[i], i);
         end
         tests_run++;
         if (got_data[i] !== 8'h00) begin
            tests_failed++; $display("FAIL default_data%0d: got %0h expected 0", i, got_data[i]);
         end
         tests_run++;
         if (got_done[i] !== (i == CH - 1)) begin
            tests_failed++; $display("FAIL default_done%0d: got %b expected %b", i, got_done[i], (i == CH - 1));
         end
      end
   endtask

   task automatic test_sawtooth();
      int exp_v [4] = '{-128, -64, 0, 63};
      apply_reset();
      cfg_write(0, FIELD_MODE, 8'h00);
      cfg_write(0, FIELD_INC,  8'h40);
      cfg_write(0, FIELD_AMP,  8'hFF);
      for (int r = 0; r < 4; r++) begin
         do_round();
         tests_run++;
         if (chan_data[0] !== 8'(exp_v[r])) begin
            tests_failed++; $display("FAIL saw_round%0d: got %0d expected %0d", r, $signed(chan_data[0]), exp_v[r]);
         end
      end
   endtask

   task automatic test_triangle();
      int exp_v [4] = '{-128, 0, 126, -1};
      apply_reset();
      cfg_write(1, FIELD_MODE, 8'h01);
      cfg_write(1, FIELD_INC,  8'h40);
      cfg_write(1, FIELD_AMP,  8'hFF);
      for (int r = 0; r < 4; r++) begin
         do_round();
         tests_run++;
         if (chan_data[1] !== 8'(exp_v[r])) begin
            tests_failed++; $display("FAIL tri_round%0d: got %0d expected %0d", r, $signed(chan_data[1]), exp_v[r]);
         end
      end
   endtask

   task automatic test_square();
      int exp_v;
      apply_reset();
      cfg_write(2, FIELD_MODE, 8'h02);
      cfg_write(2, FIELD_DUTY, 8'h40);
      cfg_write(2, FIELD_INC,  8'h20);
      cfg_write(2, FIELD_AMP,  8'hFF);
      for (int r = 0; r < 8; r++) begin
         exp_v = (r < 2) ? 126 : -127;
         do_round();
         tests_run++;
         if (chan_data[2] !== 8'(exp_v)) begin
            tests_failed++; $display("FAIL square_round%0d: got %0d expected %0d", r, $signed(chan_data[2]), exp_v);
         end
      end
   endtask

   task automatic test_noise();
      apply_reset();
      cfg_write(0, FIELD_MODE, 8'h03);
      cfg_write(0, FIELD_AMP,  8'hFF);
      do_round();
      tests_run++;
      if (chan_data[0] !== 8'(-84)) begin
         tests_failed++; $display("FAIL noise_first: got %0d expected -84", $signed(chan_data[0]));
      end
   endtask

   task automatic test_busy_ignore_and_sync();
      int cnt = 0;
      logic [DW-1:0] first_c0 = 'x;
      apply_reset();
      cfg_write(0, FIELD_INC, 8'h40);
      cfg_write(0, FIELD_AMP, 8'hFF);
      bus.next_data_strobe_i = 1'b1;
      tick();
      for (int k = 1; k <= 17; k++) begin
         bus.next_data_strobe_i = (k == 4);
         tick();
         if (bus.data_out_valid_strobe_o) begin
            if (cnt == 0) first_c0 = bus.data_o;
            cnt++;
         end
      end
      bus.next_data_strobe_i = 1'b0;
      tests_run++;
      if (cnt !== 4) begin
         tests_failed++; $display("FAIL busy_ignore_strobes: got %0d expected 4", cnt);
      end
      tests_run++;
      if (first_c0 !== 8'h80) begin
         tests_failed++; $display("FAIL busy_ignore_data: got %0d expected -128", $signed(first_c0));
      end
      // Channel 0 phase now sits at 0x40; a sync must bring it back to zero
      bus.sync_strobe_i = 1'b1;
      tick();
      bus.sync_strobe_i = 1'b0;
      do_round();
      tests_run++;
      if (chan_data[0] !== 8'h80) begin
         tests_failed++; $display("FAIL sync_restart: got %0d expected -128", $signed(chan_data[0]));
      end
   endtask

   task automatic test_reset_abort();
      int cnt = 0;
      apply_reset();
      cfg_write(0, FIELD_INC, 8'h40);
      cfg_write(0, FIELD_AMP, 8'hFF);
      bus.next_data_strobe_i = 1'b1;
      tick();
      bus.next_data_strobe_i = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         rst_n = (k == 5) ? 1'b0 : 1'b1;
         tick();
         if (k >= 5 && bus.data_out_valid_strobe_o) cnt++;
      end
      rst_n = 1'b1;
      tests_run++;
      if (cnt !== 0) begin
         tests_failed++; $display("FAIL abort_strobes: got %0d expected 0", cnt);
      end
      tests_run++;
      if (bus.data_o !== 8'h00) begin
         tests_failed++; $display("FAIL abort_data: got %0d expected 0", $signed(bus.data_o));
      end
      tests_run++;
      if (bus.busy_o !== 1'b0) begin
         tests_failed++; $display("FAIL abort_busy: got %b expected 0", bus.busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_sawtooth();
      test_triangle();
      test_square();
      test_noise();
      test_busy_ignore_and_sync();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_wave_generator.md
MULTI_WAVE_GENERATOR -- requirements
Module: multi_wave_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: sample and amplitude width in bits; the bench SHALL support values of 4 or more.
REQ-002 Parameter PHASE_WIDTH, default 8: phase accumulator width; it SHALL be greater than or equal to DATA_WIDTH.
REQ-003 Parameter CHANNELS, default 4: number of independent channels; it SHALL be 2 or more.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_i, input, 1 bit: synchronous reset, active-low.
REQ-007 Port cfg_data_i, input, DATA_WIDTH bits: configuration value.
REQ-008 Port cfg_chan_i, input, clog2(CHANNELS) bits: target channel.
REQ-009 Port cfg_field_i, input, 2 bits: 00 = phase increment, 01 = amplitude, 10 = mode (low 2 bits used), 11 = duty.
REQ-010 Port cfg_valid_strobe_i, input, 1 bit: one-cycle configuration write.
REQ-011 Port sync_strobe_i, input, 1 bit: clears all phase accumulators.
REQ-012 Port next_data_strobe_i, input, 1 bit: requests one round (one sample per channel).
REQ-013 Port data_o, output, DATA_WIDTH bits: signed two's-complement sample, registered.
REQ-014 Port data_chan_o, output, clog2(CHANNELS) bits: channel of data_o.
REQ-015 Port data_out_valid_strobe_o, output, 1 bit: one-cycle pulse marking data_o as valid.
REQ-016 Port busy_o, output, 1 bit: high while a round is in progress.
REQ-017 Port round_done_strobe_o, output, 1 bit: pulses together with the last channel's valid strobe.

Function
REQ-018 Each channel SHALL hold inc, amp (unsigned), mode, duty and a phase accumulator.
REQ-019 Configuration writes SHALL be accepted in every state and take effect the next cycle; a SHAPE step in the same cycle SHALL use the old value.
REQ-020 The FSM SHALL have states IDLE, SHAPE, SCALE and OUT.
REQ-021 In IDLE, next_data_strobe_i SHALL set busy_o, load channel index 0 and go to SHAPE.
REQ-022 next_data_strobe_i SHALL be ignored when not in IDLE; requests SHALL NOT be queued.
REQ-023 SHAPE SHALL register the shaped sample from u = the top DATA_WIDTH bits of the current channel phase, then set phase to phase + inc, modulo 2^PHASE_WIDTH.
REQ-024 SCALE SHALL register (shaped * amp) arithmetically shifted right by DATA_WIDTH (floor), truncated to DATA_WIDTH bits.
REQ-025 OUT SHALL drive data_o and data_chan_o and pulse the valid strobe; it then goes to SHAPE for the next channel, or to IDLE with busy_o low after the last channel.
REQ-026 Timing: first valid strobe 3 cycles after the request cycle, then one every 3 cycles; a round takes 3*CHANNELS cycles.
REQ-027 Mode 00, sawtooth: u with its MSB inverted.
REQ-028 Mode 01, triangle: f = (u << 1) when the MSB of u is 0, else the bitwise inverse of (u << 1), both W bits; output f with its MSB inverted.
REQ-029 Mode 10, square: +(2^(W-1) - 1) when u < duty, else -(2^(W-1) - 1).
REQ-030 Mode 11, noise: the top W bits of a shared 16-bit Fibonacci LFSR (taps 16, 14, 13, 11), read before advancing; the LFSR SHALL advance in every SHAPE cycle of any channel.
REQ-031 sync_strobe_i SHALL zero every accumulator; if it coincides with a SHAPE update, the clear SHALL win.
REQ-032 data_o SHALL hold its value between strobes.

Reset
REQ-033 Reset SHALL set data_o, data_chan_o, all strobes and busy_o to 0 and the FSM to IDLE.
REQ-034 Reset SHALL set every channel's inc, amp, mode and phase to 0 and duty to 2^(W-1).
REQ-035 Reset SHALL set the LFSR to 16'hACE1.
REQ-036 A reset during a round SHALL abort it with no further strobes.

Structure
REQ-037 Package multi_wave_pkg SHALL hold the mode codes, field codes, the FSM state enum, and the LFSR seed and taps.
REQ-038 Sub-module wave_shaper (combinational: u, mode, duty, LFSR value in; shaped sample out) SHALL implement REQ-027 to REQ-030.

Verification (W = 8, PW = 8, CH = 4)
REQ-039 Defaults: reset then one request -> strobes at cycles +3, +6, +9, +12; data 0; channels 0 to 3; round_done on the 4th strobe.
REQ-040 Channel 0 sawtooth, inc 0x40, amp 0xFF, four rounds -> channel 0 outputs -128, -64, 0, 63.
REQ-041 Channel 1 triangle, inc 0x40, amp 0xFF, four rounds -> -128, 0, 126, -1.
REQ-042 Channel 2 square, duty 0x40, inc 0x20, amp 0xFF, eight rounds -> 126, 126, then -127 six times.
REQ-043 Channel 0 noise, amp 0xFF, first request after reset -> channel 0 outputs -84 (LFSR top byte 0xAC).
REQ-044 Control: a request while busy is ignored (exactly 4 strobes); sync_strobe_i then a request gives sawtooth -128 again; rst_i low at cycle +5 gives no strobe and data_o = 0.
